// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized line, oversampled majority-vote bit sampling, optional parity, 1 or 2 stop bits.
// Optional break detection (break_o port) is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_core #(
    parameter logic [7:0] OVERSAMPLE = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        rx_i,
    input  logic [1:0]  parity,
    input  logic        stop2,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_err_o,
    output logic        par_err_o,
    output logic        overrun_o,
`ifdef UART_RX_BREAK_DET_EN
    output logic        break_o,
`endif
    output logic        busy_o
);

    localparam logic [7:0] OS_LAST = OVERSAMPLE - 8'd1;
    localparam logic [7:0] OS_S0   = (OVERSAMPLE >> 1) - 8'd1;
    localparam logic [7:0] OS_S1   = OVERSAMPLE >> 1;
    localparam logic [7:0] OS_S2   = (OVERSAMPLE >> 1) + 8'd1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2} state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]  sync_q, sync_d;
    logic [1:0]  prime_q, prime_d;
    logic        rx_s;
    logic [15:0] div_q, div_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [7:0]  os_q, os_d;
    logic [1:0]  samp_q, samp_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  par_sel_q, par_sel_d;
    logic        stop2_sel_q, stop2_sel_d;
    logic        fe_q, fe_d;
    logic        pe_q, pe_d;
    logic        idle_ok_q, idle_ok_d;
    logic        start_ok;
    logic        maj;
    logic        frame_done;
    logic        accept;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        par_err_q, par_err_d;
    logic        overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
    logic        brk_q, brk_d;
    logic        brk_wait_q, brk_wait_d;
    logic [7:0]  hi_cnt_q, hi_cnt_d;
    logic        break_q, break_d;
`endif

    // The synchronizer resets to 1, so its output is not trusted as "line idle"
    // until two clocks after reset release (prime_q).
    always_comb begin
        sync_d  = {sync_q[0], rx_i};
        prime_d = {prime_q[0], 1'b1};
        tick    = (div_q == 16'd0);
        div_d   = tick ? baud_div : div_q - 16'd1;
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_BREAK_DET_EN
    assign start_ok = idle_ok_q & ~brk_wait_q;
`else
    assign start_ok = idle_ok_q;
`endif

    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        samp_d      = samp_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_sel_d   = par_sel_q;
        stop2_sel_d = stop2_sel_q;
        fe_d        = fe_q;
        pe_d        = pe_q;
        idle_ok_d   = idle_ok_q;
        frame_done  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d      = brk_q;
        brk_wait_d = brk_wait_q;
        hi_cnt_d   = hi_cnt_q;
`endif
        maj = majority3(samp_q[0], samp_q[1], rx_s);

        if (tick) begin
            if (state_q == IDLE) begin
`ifdef UART_RX_BREAK_DET_EN
                // After a break the line must be high for a whole bit time.
                if (brk_wait_q) begin
                    if (!rx_s) begin
                        hi_cnt_d = 8'd0;
                    end else if (hi_cnt_q == OS_LAST) begin
                        brk_wait_d = 1'b0;
                        hi_cnt_d   = 8'd0;
                    end else begin
                        hi_cnt_d = hi_cnt_q + 8'd1;
                    end
                end
`endif
                if (!rx_s && start_ok) begin
                    state_d     = START;
                    os_d        = 8'd0;
                    bit_cnt_d   = 3'd0;
                    fe_d        = 1'b0;
                    pe_d        = 1'b0;
                    par_sel_d   = parity;
                    stop2_sel_d = stop2;
`ifdef UART_RX_BREAK_DET_EN
                    brk_d = 1'b0;
`endif
                end else if (rx_s && prime_q[1]) begin
                    idle_ok_d = 1'b1;
                end
            end else begin
                if (os_q == OS_S0) samp_d[0] = rx_s;
                if (os_q == OS_S1) samp_d[1] = rx_s;
                os_d = (os_q == OS_LAST) ? 8'd0 : os_q + 8'd1;

                case (state_q)
                    START: begin
                        if (os_q == OS_S2 && maj) begin
                            state_d = IDLE;
                            os_d    = 8'd0;
                        end else if (os_q == OS_LAST) begin
                            state_d = DATA;
                        end
                    end
                    DATA: begin
                        if (os_q == OS_S2) shift_d = {maj, shift_q[7:1]};
                        if (os_q == OS_LAST) begin
                            if (bit_cnt_q == 3'd7) begin
                                state_d = (par_sel_q == 2'd1 || par_sel_q == 2'd2) ? PAR : STOP1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    PAR: begin
                        if (os_q == OS_S2) pe_d = maj ^ (^shift_q ^ (par_sel_q == 2'd2));
                        if (os_q == OS_LAST) state_d = STOP1;
                    end
                    STOP1: begin
                        if (os_q == OS_S2) begin
                            fe_d = ~maj;
`ifdef UART_RX_BREAK_DET_EN
                            brk_d = (shift_q == 8'h00) && !maj;
`endif
                            if (!stop2_sel_q) begin
                                frame_done = 1'b1;
                                state_d    = IDLE;
                                os_d       = 8'd0;
                            end
                        end else if (os_q == OS_LAST) begin
                            state_d = STOP2;
                        end
                    end
                    STOP2: begin
                        if (os_q == OS_S2) begin
                            fe_d       = fe_q | ~maj;
                            frame_done = 1'b1;
                            state_d    = IDLE;
                            os_d       = 8'd0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        os_d    = 8'd0;
                    end
                endcase
            end
        end

        // A completed frame returns to IDLE mid-stop-bit; the next low tick may start a frame.
        if (frame_done) begin
            idle_ok_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            if (brk_d) begin
                brk_wait_d = 1'b1;
                hi_cnt_d   = 8'd0;
            end
`endif
        end
    end

    always_comb begin
        accept      = valid_q & ready_i;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        par_err_d   = par_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        break_d = break_q;
`endif
        if (frame_done) begin
            if (!valid_q || accept) begin
                data_d      = shift_q;
                frame_err_d = fe_d;
                par_err_d   = pe_q;
                valid_d     = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                break_d = brk_d;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            prime_q     <= 2'b00;
            div_q       <= 16'd0;
            state_q     <= IDLE;
            os_q        <= 8'd0;
            samp_q      <= 2'b00;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_sel_q   <= 2'd0;
            stop2_sel_q <= 1'b0;
            fe_q        <= 1'b0;
            pe_q        <= 1'b0;
            idle_ok_q   <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= 1'b0;
            brk_wait_q <= 1'b0;
            hi_cnt_q   <= 8'd0;
            break_q    <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            prime_q     <= prime_d;
            div_q       <= div_d;
            state_q     <= state_d;
            os_q        <= os_d;
            samp_q      <= samp_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_sel_q   <= par_sel_d;
            stop2_sel_q <= stop2_sel_d;
            fe_q        <= fe_d;
            pe_q        <= pe_d;
            idle_ok_q   <= idle_ok_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= brk_d;
            brk_wait_q <= brk_wait_d;
            hi_cnt_q   <= hi_cnt_d;
            break_q    <= break_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign par_err_o   = par_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign break_o     = break_q & valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core; expected results come from a
// frame-level model (data byte, parity by ones-count, stop-bit levels).
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int OS = 16;
    localparam int SPIKE_AT = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_i;
    logic [1:0]  parity;
    logic        stop2;
    logic        ready_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        par_err_o;
    logic        overrun_o;
    logic        busy_o;
`ifdef UART_RX_BREAK_DET_EN
    logic        break_o;
    logic        got_brk [64];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int bit_clks = OS;
    int rd_idx = 0;

    logic [7:0] got_data [64];
    logic       got_fe [64];
    logic       got_pe [64];
    int         got_n = 0;
    int         ovr_cnt = 0;
    int         vld_cycles = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.OVERSAMPLE(8'd16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .rx_i        (rx_i),
        .parity      (parity),
        .stop2       (stop2),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .par_err_o   (par_err_o),
        .overrun_o   (overrun_o),
`ifdef UART_RX_BREAK_DET_EN
        .break_o     (break_o),
`endif
        .busy_o      (busy_o)
    );

    // Accepted-byte collector and pulse counters.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_o && ready_i && got_n < 64) begin
                got_data[got_n] <= data_o;
                got_fe[got_n]   <= frame_err_o;
                got_pe[got_n]   <= par_err_o;
`ifdef UART_RX_BREAK_DET_EN
                got_brk[got_n]  <= break_o;
`endif
                got_n <= got_n + 1;
            end
            if (overrun_o) ovr_cnt <= ovr_cnt + 1;
            if (valid_o) vld_cycles <= vld_cycles + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Parity bit a correct transmitter appends: makes the total count of ones even (mode 1) or odd (mode 2).
    function automatic logic ref_par_bit(input logic [7:0] b, input logic [1:0] pm);
        int ones;
        ones = $countones(b);
        if (pm == 2'd2) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    task automatic drive_bit(input logic v, input logic spk);
        for (int c = 0; c < bit_clks; c++) begin
            rx_i = (spk && c == SPIKE_AT) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * bit_clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [1:0] pm, input logic s2,
                              input logic pb, input logic s1v, input logic s2v, input int spike_bit);
        parity = pm;
        stop2  = s2;
        drive_bit(1'b0, 1'b0);
        // Frame format is latched at start detection; later changes must not matter.
        parity = 2'($urandom_range(0, 3));
        stop2  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) drive_bit(b[i], spike_bit == i);
        if (pm == 2'd1 || pm == 2'd2) drive_bit(pb, 1'b0);
        drive_bit(s1v, 1'b0);
        if (s2) drive_bit(s2v, 1'b0);
        rx_i = 1'b1;
    endtask

    task automatic check_rec(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        chk({tag, "_count"}, got_n - rd_idx, 1);
        if (got_n > rd_idx) begin
            chk({tag, "_data"}, got_data[rd_idx], d);
            chk({tag, "_ferr"}, got_fe[rd_idx], fe);
            chk({tag, "_perr"}, got_pe[rd_idx], pe);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic [1:0] pm,
                               input logic s2, input logic pb, input logic s1v, input logic s2v);
        logic epe;
        logic efe;
        epe = (pm == 2'd1 || pm == 2'd2) && (pb != ref_par_bit(b, pm));
        efe = !s1v || (s2 && !s2v);
        check_rec(tag, b, efe, epe);
`ifdef UART_RX_BREAK_DET_EN
        if (got_n > rd_idx) chk({tag, "_brk"}, got_brk[rd_idx], (b == 8'h00) && !s1v);
`endif
        rd_idx = got_n;
    endtask

    initial begin
        logic [7:0] b;
        logic [1:0] pm;
        logic       s2, pb, s1v, s2v;
        int         v0, o0, kind;

        rst_n = 1'b0; baud_div = 16'd0; rx_i = 1'b1; parity = 2'd0; stop2 = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_o, 8'h00);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ferr", frame_err_o, 1'b0);
        chk("rst_perr", par_err_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);

        // Plain 8N1 byte, consumer always ready.
        v0 = vld_cycles;
        send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("norm", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("norm_valid_len", vld_cycles - v0, 1);

        // Even parity, wrong and right parity bit.
        send_frame(8'h03, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("even_bad", 8'h03, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h03, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("even_ok", 8'h03, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Short low glitch on an idle line, then a spike on one sample of a data bit.
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        chk("glitch_none", got_n - rd_idx, 0);
        chk("glitch_idle", busy_o, 1'b0);
        send_frame(8'hF0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        idle_bits(2);
        check_frame("spike", 8'hF0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom_range(0, 255));
            pm  = 2'($urandom_range(0, 3));
            s2  = 1'($urandom_range(0, 1));
            pb  = ref_par_bit(b, pm);
            s1v = 1'b1;
            s2v = 1'b1;
            kind = $urandom_range(0, 5);
            if (kind == 0) pb = ~pb;
            else if (kind == 1) s1v = 1'b0;
            else if (kind == 2) s2v = 1'b0;
            send_frame(b, pm, s2, pb, s1v, s2v, -1);
            idle_bits(2);
            check_frame($sformatf("rand%0d", i), b, pm, s2, pb, s1v, s2v);
        end

        // Overrun: second byte arrives while the first is still unaccepted.
        ready_i = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        chk("ovr_data_kept", data_o, 8'h11);
        chk("ovr_valid_held", valid_o, 1'b1);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_none_taken", got_n - rd_idx, 0);
        @(posedge clk);
        #1 ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_frame("ovr_accept", 8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_valid_clear", valid_o, 1'b0);

        // Two stop bits, second one low.
        send_frame(8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle_bits(2);
        check_frame("stop2_ferr", 8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the data bits.
        parity = 2'd0; stop2 = 1'b0;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        @(posedge clk);
        #2;
        chk("mid_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data_o, 8'h00);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_ferr", frame_err_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        chk("mid_rst_no_partial", got_n - rd_idx, 0);
        send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("after_rst", 8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Line held low through reset release must not start a frame.
        rst_n = 1'b0;
        rx_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * bit_clks) @(negedge clk);
        chk("low_rel_busy", busy_o, 1'b0);
        chk("low_rel_none", got_n - rd_idx, 0);
        idle_bits(1);
        send_frame(8'hC3, 2'd2, 1'b0, ref_par_bit(8'hC3, 2'd2), 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("low_rel_frame", 8'hC3, 2'd2, 1'b0, ref_par_bit(8'hC3, 2'd2), 1'b1, 1'b1);

        // Long low line: break (detection build) or plain framing error.
        parity = 2'd0; stop2 = 1'b0;
        rx_i = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        repeat (20 * bit_clks) @(negedge clk);
`else
        repeat (10 * bit_clks) @(negedge clk);
`endif
        idle_bits(2);
        check_frame("break", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("post_break", 8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Slower baud: tick every second clock, 32 clocks per bit.
        baud_div = 16'd1;
        bit_clks = 2 * OS;
        idle_bits(1);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 2'd1, 1'b1, ref_par_bit(b, 2'd1), 1'b1, 1'b1, -1);
        idle_bits(2);
        check_frame("slow_baud", b, 2'd1, 1'b1, ref_par_bit(b, 2'd1), 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
